// File: rtl/apb_master.sv
// apb_master: APB4 master bridge.
// Turns a single-request user interface (transfer/addr_in/wdata_in/...) into
// APB IDLE -> SETUP -> ACCESS sequences. It honours wait states and returns
// read data, a completion pulse and slave error to the user side.
// Back-to-back requests go straight from ACCESS to SETUP without an IDLE cycle.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES consecutive PREADY=0 cycles. An aborted transfer
// reports transfer_done=1 and error=1. Without the macro the master waits
// for PREADY indefinitely.
//
// Reset: PRESETn is synchronous and active-high (despite its name).
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // user side
  input  logic                    transfer,
  input  logic                    write_read,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [DATA_WIDTH/8-1:0] strb_in,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic                    transfer_done,
  output logic                    error,
  // APB side
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // complete: the ACCESS phase ends at this edge (PREADY or timeout).
  // accept:   a new user request is latched at this edge.
  logic complete;
  logic accept;
  logic timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Number of PREADY=0 cycles already spent in the current ACCESS phase.
  logic [CNT_W-1:0] wait_cnt;

  // The abort fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign timeout = (state == S_ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

  // Count wait cycles; cleared whenever we are not in ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      wait_cnt <= '0;
    end else if (state != S_ACCESS) begin
      wait_cnt <= '0;
    end else if (!PREADY && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the completion/accept strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    next_state = state;
    complete   = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (transfer) begin
          accept     = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        next_state = S_ACCESS;
      end
      S_ACCESS: begin
        // PSLVERR/PRDATA are only meaningful once PREADY (or the timeout)
        // closes the phase; otherwise we simply stay here.
        if (PREADY || timeout) begin
          complete = 1'b1;
          if (transfer) begin
            accept     = 1'b1;
            next_state = S_SETUP;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // APB control outputs, registered from the next state so they line up
  // exactly with the state the FSM is entering.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      PSEL    <= (next_state != S_IDLE);
      PENABLE <= (next_state == S_ACCESS);
    end
  end

  // Request capture: address/data/strobes only change when a request is
  // accepted, so they stay stable through wait states and hold in IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PADDR  <= addr_in;
      PWRITE <= write_read;
      PWDATA <= wdata_in;
      // Reads never carry strobes on the bus.
      PSTRB  <= write_read ? strb_in : {STRB_WIDTH{1'b0}};
    end
  end

  // User-side response: one-cycle done/error pulses and read data capture.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      transfer_done <= 1'b0;
      error         <= 1'b0;
      rdata_out     <= '0;
    end else begin
      transfer_done <= complete;
      // On a timeout PREADY is low, so PSLVERR is not consulted.
      error         <= complete && (timeout || PSLVERR);
      // Only a genuine read completion updates rdata_out; writes and
      // timeouts leave the last read value in place.
      if (complete && PREADY && !PWRITE) begin
        rdata_out <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a response scoreboard.
// Expected completions are queued when a request is issued and popped when
// transfer_done is seen. Define APB_MASTER_TIMEOUT_EN to also cover the
// timeout abort.
module tb_apb_master;

  localparam int ADDR_WIDTH     = 8;
  localparam int DATA_WIDTH     = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic                    PCLK = 1'b0;
  logic                    PRESETn;
  logic                    transfer;
  logic                    write_read;
  logic [ADDR_WIDTH-1:0]   addr_in;
  logic [DATA_WIDTH-1:0]   wdata_in;
  logic [DATA_WIDTH/8-1:0] strb_in;
  logic [DATA_WIDTH-1:0]   rdata_out;
  logic                    transfer_done;
  logic                    error;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  apb_master #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .transfer     (transfer),
    .write_read   (write_read),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .strb_in      (strb_in),
    .rdata_out    (rdata_out),
    .transfer_done(transfer_done),
    .error        (error),
    .PADDR        (PADDR),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PWDATA       (PWDATA),
    .PSTRB        (PSTRB),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } exp_t;

  exp_t                  sb[$];
  logic [DATA_WIDTH-1:0] model_rdata = '0;
  int                    checks      = 0;
  int                    failures    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after it.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Compare the oldest scoreboard entry against the user-side response.
  task automatic sb_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rdata_out, e.rdata);
      check({tag, "_error"}, 32'(error), 32'(e.err));
    end
  endtask

  // One isolated transfer with 'waits' PREADY=0 ACCESS cycles. PSLVERR is
  // held high during wait cycles to show it is ignored without PREADY.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int waits,
                      input logic [31:0] prd, input logic serr);
    exp_t e;
    int   cnt;
    int   exp_cycles;
    bit   done;
    bit   to;
    to = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    to = (waits >= TIMEOUT_CYCLES);
`endif
    exp_cycles  = to ? TIMEOUT_CYCLES : waits + 1;
    e.err       = serr | to;
    e.rdata     = (wr || to) ? model_rdata : prd;
    model_rdata = e.rdata;
    sb.push_back(e);

    transfer = 1'b1; write_read = wr; addr_in = a; wdata_in = d; strb_in = s;
    PREADY = 1'b0; PRDATA = prd; PSLVERR = 1'b1;
    step();
    // Scramble user inputs: they must be ignored until completion.
    transfer = 1'b0; addr_in = ~a; wdata_in = ~d; write_read = ~wr;
    check({tag, "_setup_psel"},    32'(PSEL),    32'd1);
    check({tag, "_setup_penable"}, 32'(PENABLE), 32'd0);
    check({tag, "_setup_paddr"},   32'(PADDR),   32'(a));
    check({tag, "_setup_pwrite"},  32'(PWRITE),  32'(wr));
    check({tag, "_setup_pwdata"},  PWDATA,       d);
    check({tag, "_setup_pstrb"},   32'(PSTRB),   wr ? 32'(s) : 32'd0);

    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < waits + 20 && !done; i++) begin
      step();
      if (transfer_done) begin
        done = 1'b1;
      end else begin
        if (PENABLE) cnt++;
        check({tag, "_hold_paddr"}, 32'(PADDR), 32'(a));
        check({tag, "_hold_psel"},  32'(PSEL),  32'd1);
        PREADY  = (cnt == waits + 1);
        PSLVERR = PREADY ? serr : 1'b1;
      end
    end
    check({tag, "_done_seen"},      32'(done), 32'd1);
    check({tag, "_penable_cycles"}, cnt,       exp_cycles);
    sb_compare(tag);
    check({tag, "_idle_psel"},    32'(PSEL),    32'd0);
    check({tag, "_idle_penable"}, 32'(PENABLE), 32'd0);
    PREADY = 1'b0; PSLVERR = 1'b0;
    step();
    check({tag, "_done_pulse_end"},  32'(transfer_done), 32'd0);
    check({tag, "_error_pulse_end"}, 32'(error),         32'd0);
    check({tag, "_idle_paddr_hold"}, 32'(PADDR),         32'(a));
  endtask

  initial begin
    exp_t e;
    PRESETn = 1'b1; transfer = 1'b0; write_read = 1'b0; addr_in = '0;
    wdata_in = '0; strb_in = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    step();
    step();
    check("rst_psel",    32'(PSEL),          32'd0);
    check("rst_penable", 32'(PENABLE),       32'd0);
    check("rst_pwrite",  32'(PWRITE),        32'd0);
    check("rst_paddr",   32'(PADDR),         32'd0);
    check("rst_pwdata",  PWDATA,             32'd0);
    check("rst_pstrb",   32'(PSTRB),         32'd0);
    check("rst_rdata",   rdata_out,          32'd0);
    check("rst_done",    32'(transfer_done), 32'd0);
    check("rst_error",   32'(error),         32'd0);
    PRESETn = 1'b0;
    step();
    check("idle_psel", 32'(PSEL), 32'd0);

    xfer("wr0",    1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0BAD0BAD, 1'b0);
    xfer("rd3",    1'b0, 8'h24, 32'h00000000, 4'hF, 3, 32'h12345678, 1'b0);
    xfer("wrerr",  1'b1, 8'h30, 32'h11223344, 4'h5, 0, 32'hFFFFFFFF, 1'b1);
    xfer("rderr2", 1'b0, 8'h44, 32'hA0A0A0A0, 4'h3, 2, 32'h55AA55AA, 1'b1);
    xfer("wr1",    1'b1, 8'hFF, 32'h00000001, 4'h8, 1, 32'h77777777, 1'b0);

    // Back-to-back: write 0x04 then read 0x08 with transfer held high.
    e.err = 1'b0; e.rdata = model_rdata; sb.push_back(e);
    transfer = 1'b1; write_read = 1'b1; addr_in = 8'h04; wdata_in = 32'hA5A5A5A5;
    strb_in = 4'h3; PREADY = 1'b1; PRDATA = 32'hCAFEF00D; PSLVERR = 1'b0;
    step();
    check("b2b_setup1_psel",  32'(PSEL),  32'd1);
    check("b2b_setup1_paddr", 32'(PADDR), 32'h04);
    check("b2b_setup1_pstrb", 32'(PSTRB), 32'h3);
    write_read = 1'b0; addr_in = 8'h08; wdata_in = 32'h0; strb_in = 4'hF;
    e.err = 1'b0; e.rdata = 32'hCAFEF00D; model_rdata = e.rdata; sb.push_back(e);
    step();
    check("b2b_access1_penable", 32'(PENABLE),       32'd1);
    check("b2b_access1_paddr",   32'(PADDR),         32'h04);
    check("b2b_access1_done",    32'(transfer_done), 32'd0);
    step();
    check("b2b_done1", 32'(transfer_done), 32'd1);
    sb_compare("b2b_first");
    check("b2b_setup2_psel",    32'(PSEL),    32'd1);
    check("b2b_setup2_penable", 32'(PENABLE), 32'd0);
    check("b2b_setup2_paddr",   32'(PADDR),   32'h08);
    check("b2b_setup2_pwrite",  32'(PWRITE),  32'd0);
    check("b2b_setup2_pstrb",   32'(PSTRB),   32'd0);
    transfer = 1'b0;
    step();
    check("b2b_access2_psel", 32'(PSEL),          32'd1);
    check("b2b_access2_done", 32'(transfer_done), 32'd0);
    step();
    check("b2b_done2", 32'(transfer_done), 32'd1);
    sb_compare("b2b_second");
    check("b2b_end_psel", 32'(PSEL), 32'd0);
    PREADY = 1'b0;
    step();

    // Reset asserted while ACCESS is waiting on PREADY.
    transfer = 1'b1; write_read = 1'b0; addr_in = 8'h5C; PREADY = 1'b0;
    PRDATA = 32'h99999999;
    step();
    transfer = 1'b0;
    step();
    step();
    check("rstmid_waiting_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b1;
    step();
    model_rdata = '0;
    check("rstmid_psel",    32'(PSEL),          32'd0);
    check("rstmid_penable", 32'(PENABLE),       32'd0);
    check("rstmid_paddr",   32'(PADDR),         32'd0);
    check("rstmid_done",    32'(transfer_done), 32'd0);
    check("rstmid_error",   32'(error),         32'd0);
    check("rstmid_rdata",   rdata_out,          32'd0);
    PRESETn = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_no_done", 32'(transfer_done), 32'd0);
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    xfer("post_rst_rd", 1'b0, 8'h60, 32'h0, 4'hF, 0, 32'h0F0F0F0F, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer("timeout", 1'b0, 8'h70, 32'h0, 4'hF, 100, 32'h31415926, 1'b0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
